// File: rtl/mips_enc_pkg.sv
// Shared encodings for the MIPS instruction stream encoder: ALU op codes, operand-source
// selectors, opcode/funct fields and the combinational encode function.
package mips_enc_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_ZEXT = 2'b01;
  localparam logic [1:0] SRC2_SEXT = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_result_t;

  // ok=0 marks an operation with no single-instruction MIPS encoding.
  function automatic enc_result_t encode(input logic [2:0]  alu_op,
                                         input logic [1:0]  src2,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm);
    enc_result_t r;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    r      = '0;
    funct  = '0;
    opcode = '0;
    case (src2)
      SRC2_REG: begin
        r.ok = 1'b1;
        case (alu_op)
          ALU_ADD: funct = F_ADD;
          ALU_SUB: funct = F_SUB;
          ALU_AND: funct = F_AND;
          ALU_OR:  funct = F_OR;
          ALU_XOR: funct = F_XOR;
          ALU_NOR: funct = F_NOR;
          default: r.ok = 1'b0;
        endcase
        r.word = {OP_RTYPE, rs, rt, rd, 5'h00, funct};
      end
      SRC2_SEXT: begin
        r.ok   = (alu_op == ALU_ADD);
        r.word = {OP_ADDI, rs, rt, imm};
      end
      SRC2_ZEXT: begin
        r.ok = 1'b1;
        case (alu_op)
          ALU_AND: opcode = OP_ANDI;
          ALU_OR:  opcode = OP_ORI;
          ALU_XOR: opcode = OP_XORI;
          default: r.ok = 1'b0;
        endcase
        r.word = {opcode, rs, rt, imm};
      end
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// DEPTH x WIDTH ready/valid FIFO holding encoded instruction words; head is shown combinationally.
module mips_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is cleared on reset so the visible head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_encode_stream.sv
// Encodes abstract ALU operations into MIPS words and streams them with sequential addresses.
// Define MIPS_ENC_ERRCNT_EN to build the saturating dropped-operation counter on err_count.
module mips_encode_stream
  import mips_enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [1:0]  alu_src2,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  enc_result_t enc;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;
  logic [31:0] addr_q;
  logic        err_q;

  assign enc = encode(alu_op, alu_src2, rs, rt, rd, imm);

  // No pop bypass: a slot freed this cycle is only offered on the next one.
  assign in_ready  = reset | ~fifo_full;
  assign accept    = in_valid & in_ready & ~reset;
  assign push      = accept & enc.ok;
  assign drop      = accept & ~enc.ok;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_addr  = addr_q;
  assign err       = err_q;

  mips_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (enc.word),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_word)
  );

  // Address advances only when a word leaves; 32-bit wrap is intentional.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + 32'd4;
      end
      err_q <= drop;
    end
  end

`ifdef MIPS_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (drop && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_mips_encode_stream.sv
// Directed bench for mips_encode_stream: encoding, illegal drops, backpressure, reset, addr wrap.
module tb_mips_encode_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src2;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_word, out_addr;
  logic        err;
  logic [7:0]  err_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
  logic [31:0] w_out_word, w_out_addr;
  logic [7:0]  w_err_count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MIPS_ENC_ERRCNT_EN
  localparam logic [7:0] ExpCnt1 = 8'd1;
  localparam logic [7:0] ExpCnt2 = 8'd2;
`else
  localparam logic [7:0] ExpCnt1 = 8'd0;
  localparam logic [7:0] ExpCnt2 = 8'd0;
`endif

  logic [31:0] exp_words [5] = '{32'h00222020, 32'h00222822, 32'h00223027,
                                 32'h3043ABCD, 32'h38691234};

  always #5 clk = ~clk;

  mips_encode_stream dut (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
    .alu_op (alu_op), .alu_src2 (alu_src2), .rs (rs), .rt (rt), .rd (rd), .imm (imm),
    .out_valid (out_valid), .out_ready (out_ready), .out_word (out_word),
    .out_addr (out_addr), .err (err), .err_count (err_count)
  );

  mips_encode_stream #(.DEPTH (4), .BASE_ADDR (32'hFFFF_FFF8)) dut_wrap (
    .clk (clk), .reset (reset), .in_valid (w_in_valid), .in_ready (w_in_ready),
    .alu_op (alu_op), .alu_src2 (alu_src2), .rs (rs), .rt (rt), .rd (rd), .imm (imm),
    .out_valid (w_out_valid), .out_ready (w_out_ready), .out_word (w_out_word),
    .out_addr (w_out_addr), .err (w_err), .err_count (w_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [1:0] s2, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [15:0] i);
    alu_op = op; alu_src2 = s2; rs = a; rt = b; rd = d; imm = i;
  endtask

  task automatic push_op(input logic [2:0] op, input logic [1:0] s2, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic [15:0] i);
    set_op(op, s2, a, b, d, i);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    set_op(3'b010, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_addr", out_addr, 32'h00400000);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // Basic R-type add, latency 1.
    push_op(3'b010, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_word", out_word, 32'h00221820);
    check("add_addr", out_addr, 32'h00400000);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pop_empty", 32'(out_valid), 32'd0);
    check("pop_addr", out_addr, 32'h00400004);

    // I-type forms.
    push_op(3'b010, 2'b10, 5'd4, 5'd5, 5'd31, 16'hFFFF);
    check("addi_word", out_word, 32'h2085FFFF);
    check("addi_addr", out_addr, 32'h00400004);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_op(3'b101, 2'b01, 5'd0, 5'd8, 5'd0, 16'h00FF);
    check("ori_word", out_word, 32'h340800FF);
    check("ori_addr", out_addr, 32'h00400008);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Illegal: sub with zero-ext immediate.
    push_op(3'b011, 2'b01, 5'd1, 5'd2, 5'd3, 16'h1234);
    check("ill_err", 32'(err), 32'd1);
    check("ill_no_word", 32'(out_valid), 32'd0);
    check("ill_cnt", 32'(err_count), 32'(ExpCnt1));
    tick();
    check("ill_err_clr", 32'(err), 32'd0);
    push_op(3'b000, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    check("ill2_err", 32'(err), 32'd1);
    check("ill2_cnt", 32'(err_count), 32'(ExpCnt2));
    push_op(3'b010, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    check("after_ill_err", 32'(err), 32'd0);
    check("after_ill_word", out_word, 32'h00221820);
    check("after_ill_addr", out_addr, 32'h0040000C);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: fill, hold a 5th, pop one, then drain in order.
    do_reset();
    check("fill_ready0", 32'(in_ready), 32'd1);
    push_op(3'b010, 2'b00, 5'd1, 5'd2, 5'd4, 16'h0);
    push_op(3'b011, 2'b00, 5'd1, 5'd2, 5'd5, 16'h0);
    push_op(3'b110, 2'b00, 5'd1, 5'd2, 5'd6, 16'h0);
    check("fill_ready3", 32'(in_ready), 32'd1);
    push_op(3'b100, 2'b01, 5'd2, 5'd3, 5'd0, 16'hABCD);
    check("full_ready", 32'(in_ready), 32'd0);
    set_op(3'b111, 2'b01, 5'd3, 5'd9, 5'd0, 16'h1234);
    in_valid = 1'b1;
    tick();
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check("full_hold_head", out_word, 32'h00222020);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("freed_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("refull_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("drain_word%0d", i), out_word, exp_words[i + 1]);
      check($sformatf("drain_addr%0d", i), out_addr, 32'h00400004 + 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);

    // Reset with buffered words discards everything.
    push_op(3'b111, 2'b10, 5'd1, 5'd1, 5'd1, 16'h1);
    push_op(3'b010, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    push_op(3'b100, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    push_op(3'b101, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_addr", out_addr, 32'h00400000);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);

    // Address wrap on the second instance.
    set_op(3'b010, 2'b00, 5'd1, 5'd2, 5'd3, 16'h0);
    w_in_valid = 1'b1;
    tick(); tick(); tick();
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    check("wrap_addr0", w_out_addr, 32'hFFFFFFF8);
    tick();
    check("wrap_addr1", w_out_addr, 32'hFFFFFFFC);
    tick();
    check("wrap_addr2", w_out_addr, 32'h00000000);
    check("wrap_word2", w_out_word, 32'h00221820);
    tick();
    check("wrap_empty", 32'(w_out_valid), 32'd0);
    check("wrap_addr3", w_out_addr, 32'h00000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
